fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the dual-clock FIFO (wr_en/buf_in/buf_full) between several producers in the write-clock domain. Each producer offers data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO write port combinationally from the granted producer. It stalls on buf_full without losing or duplicating data.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 8, data width; matches FIFO buf_in
- MAX_BURST, 4, maximum beats per grant (1..15)

Ports:
- clk_w  in  1  write-domain clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-producer accept; a beat transfers when req_valid[i] & req_ready[i]
- buf_full  in  1  FIFO full flag (write side)
- wr_en  out  1  FIFO write enable
- buf_in  out  DATA_W  FIFO write data
- grant  out  NUM_REQ  one-hot current grant; 0 when idle
- busy  out  1  1 when state is GRANT
- wr_count  out  16  total beats written since reset; wraps 0xFFFF -> 0

## Operation
- States: IDLE, GRANT. Registers: state, grant (one-hot), rr_ptr (index of the highest-priority requester), beat_cnt (4 bits), wr_count.
- Arbitration event: every edge in IDLE, and the release edge in GRANT. Pick the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. On a pick: grant <= onehot(i), beat_cnt <= 0, state <= GRANT, rr_ptr <= (i+1) mod NUM_REQ. No valid: state <= IDLE, grant <= 0, rr_ptr unchanged.
- Transfer (combinational): g = granted index; xfer = (state==GRANT) & req_valid[g] & !buf_full & !rst. wr_en = xfer. req_ready = grant masked by !buf_full & !rst. buf_in = req_data[g] when granted, else 0.
- On xfer: beat_cnt++, wr_count++.
- Release conditions in GRANT, evaluated at the edge:
  - (a) xfer and beat_cnt==MAX_BURST-1 (last beat)
  - (b) req_valid[g]==0 (producer ended its burst early)
  - Release triggers an arbitration event at the same edge. The released producer has the lowest priority, but it is re-granted if it is the only one valid.
- buf_full in GRANT: no transfer. beat_cnt and grant are held. Stalling never releases the grant.
- Producer contract: once req_valid[i]=1, data stays stable until the beat is accepted. The arbiter does not check this.
- Reset: rst=1 at an edge forces state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, wr_count=0. While rst=1, wr_en and req_ready are held at 0 combinationally, so no write occurs during the reset cycle, including mid-burst.

## Timing
- Reset values: wr_en=0, req_ready=0, buf_in=0, grant=0, busy=0, wr_count=0.
- Arbitration latency: req_valid rising before edge N gives grant at edge N. The first write is in the cycle after edge N, committed at edge N+1.
- Back-to-back bursts: wr_en stays high across the release edge when another (or the same) producer is valid. There is no bubble between bursts.
- buf_full affects wr_en/req_ready in the same cycle, with no registering.
- Maximum wait for a continuously valid producer: (NUM_REQ-1)*MAX_BURST beats plus full-stall cycles.
- beat_cnt never exceeds MAX_BURST-1. wr_count increments exactly once per wr_en cycle.

## Test plan
(Default parameters.)
- Reset: hold rst 3 cycles with all req_valid=1 -> wr_en=0, req_ready=0, grant=0, wr_count=0 throughout. The first grant is to producer 0 on the edge after rst falls.
- Single producer: req_valid=4'b0010, data 0x10..0x15 (6 beats) -> grant=4'b0010 after one edge. wr_en high for 6 consecutive cycles, 4-beat release then re-grant with no gap. buf_in sequence 0x10..0x15; wr_count=6.
- All four valid continuously, each producer sending its index*0x10+beat -> grant order 0,1,2,3,0. Each grant lasts 4 beats; wr_en is never low after the first grant.
- Full stall: producer 2 mid-burst after 2 beats, buf_full=1 for 3 cycles -> wr_en=0 and req_ready=0 for those 3 cycles. grant stays 4'b0100 and beat_cnt stays 2. The burst then completes with exactly 2 more beats and no duplicated data.
- Early release: producer 1 drops req_valid after 2 beats while producer 3 is valid -> release at that edge, grant=4'b1000 at the same edge. The next write is producer 3's data; rr_ptr=0 after producer 3's grant.
- Reset mid-burst: assert rst on beat 2 of producer 0's burst -> wr_en=0 in that cycle, and wr_count=0, grant=0, IDLE after the edge. Arbitration restarts at producer 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the FIFO write port among producers
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk_w,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      buf_full,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         buf_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [15:0]               wr_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [3:0]       beat_cnt;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] pick_next;
    logic [IDX_W-1:0] scan_idx;
    logic             pick_found;
    logic             g_valid;
    logic             xfer;
    logic             release_now;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx = IDX_W'(i);
            end
        end
    end

    // Write port follows the granted producer with no register stage, so buf_full
    // and rst gate the handshake in the same cycle.
    assign g_valid     = |(grant & req_valid);
    assign xfer        = (state == GRANT) && g_valid && !buf_full && !rst;
    assign wr_en       = xfer;
    assign req_ready   = (buf_full || rst) ? '0 : grant;
    assign buf_in      = (state == GRANT) ? req_data[g_idx*DATA_W +: DATA_W] : '0;
    assign busy        = (state == GRANT);
    assign release_now = (xfer && (beat_cnt == LAST_BEAT)) || !g_valid;

    // Scan starts at rr_ptr, which already points past the last granted producer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
        pick_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge clk_w) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            wr_count <= '0;
        end else begin
            if (xfer) begin
                wr_count <= wr_count + 16'd1;
                beat_cnt <= beat_cnt + 4'd1;
            end
            if (state == IDLE || release_now) begin
                beat_cnt <= '0;
                if (pick_found) begin
                    state  <= GRANT;
                    grant  <= ONE << pick_idx;
                    rr_ptr <= pick_next;
                end else begin
                    state <= IDLE;
                    grant <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk_w;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        buf_full;
    logic        wr_en;
    logic [7:0]  buf_in;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] wr_count;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk_w     (clk_w),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .buf_full  (buf_full),
        .wr_en     (wr_en),
        .buf_in    (buf_in),
        .grant     (grant),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pdata [4][16];
    int         pcnt [4];
    int         pidx [4];
    logic [3:0] en;

    initial begin
        clk_w = 1'b0;
        forever #5 clk_w = ~clk_w;
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = en[i] && (pidx[i] < pcnt[i]);
            req_data[i*8 +: 8]  = (pidx[i] < pcnt[i]) ? pdata[i][pidx[i]] : 8'h00;
        end
    endtask

    // Scoreboard pop on each observed write; producers advance on handshake.
    task automatic tick();
        #1;
        if (wr_en) begin
            if (exp_q.size() == 0) expect_eq("wr_unexpected", 32'(wr_en), 32'd0);
            else expect_eq("wr_data", 32'(buf_in), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) pidx[i]++;
        end
        @(posedge clk_w);
        #1;
        apply();
        #1;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int n = 0; n < max_cycles && exp_q.size() > 0; n++) tick();
        expect_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        buf_full = 1'b0;
        en       = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            pcnt[i] = 0;
            pidx[i] = 0;
        end
        exp_q.delete();
        apply();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        buf_full = 1'b0;
        req_valid = '0;
        req_data  = '0;

        // Reset held with all producers valid, then 0,1,2,3,0 rotation.
        en = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            pidx[p] = 0;
            pcnt[p] = 8;
            for (int b = 0; b < 8; b++) pdata[p][b] = 8'(p * 16 + b);
        end
        apply();
        for (int r = 0; r < 3; r++) begin
            tick();
            expect_eq("rst_wr_en", 32'(wr_en), 32'd0);
            expect_eq("rst_req_ready", 32'(req_ready), 32'd0);
            expect_eq("rst_grant", 32'(grant), 32'd0);
            expect_eq("rst_wr_count", 32'(wr_count), 32'd0);
        end
        expect_eq("rst_busy", 32'(busy), 32'd0);
        expect_eq("rst_buf_in", 32'(buf_in), 32'd0);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                for (int b = 0; b < 4; b++) exp_q.push_back(8'(p * 16 + r * 4 + b));
        rst = 1'b0;
        tick();
        expect_eq("first_grant", 32'(grant), 32'd1);
        for (int k = 0; k < 32; k++) begin
            expect_eq("rr_wr_en", 32'(wr_en), 32'd1);
            expect_eq("rr_grant", 32'(grant), 32'(4'b0001 << ((k / 4) % 4)));
            tick();
        end
        expect_eq("rr_drained", 32'(exp_q.size()), 32'd0);
        expect_eq("rr_wr_count", 32'(wr_count), 32'd32);
        tick();
        expect_eq("rr_idle_grant", 32'(grant), 32'd0);
        expect_eq("rr_idle_busy", 32'(busy), 32'd0);

        // Single producer, 6 beats: re-grant across the 4-beat release with no gap.
        do_reset();
        en = 4'b0010;
        pcnt[1] = 6;
        for (int b = 0; b < 6; b++) begin
            pdata[1][b] = 8'(8'h10 + b);
            exp_q.push_back(8'(8'h10 + b));
        end
        apply();
        tick();
        for (int k = 0; k < 6; k++) begin
            expect_eq("single_wr_en", 32'(wr_en), 32'd1);
            expect_eq("single_grant", 32'(grant), 32'h2);
            tick();
        end
        expect_eq("single_drained", 32'(exp_q.size()), 32'd0);
        expect_eq("single_wr_count", 32'(wr_count), 32'd6);
        tick();
        expect_eq("single_idle", 32'(grant), 32'd0);

        // Full stall for 3 cycles after 2 beats of producer 2.
        do_reset();
        en = 4'b0100;
        pcnt[2] = 4;
        for (int b = 0; b < 4; b++) begin
            pdata[2][b] = 8'(8'h20 + b);
            exp_q.push_back(8'(8'h20 + b));
        end
        apply();
        tick();
        expect_eq("stall_grant0", 32'(grant), 32'h4);
        for (int k = 0; k < 2; k++) begin
            expect_eq("stall_pre_wr", 32'(wr_en), 32'd1);
            tick();
        end
        buf_full = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            expect_eq("stall_wr_en", 32'(wr_en), 32'd0);
            expect_eq("stall_ready", 32'(req_ready), 32'd0);
            expect_eq("stall_grant", 32'(grant), 32'h4);
            expect_eq("stall_beat_cnt", 32'(dut.beat_cnt), 32'd2);
            tick();
        end
        buf_full = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            expect_eq("stall_post_wr", 32'(wr_en), 32'd1);
            tick();
        end
        expect_eq("stall_drained", 32'(exp_q.size()), 32'd0);
        expect_eq("stall_wr_count", 32'(wr_count), 32'd4);

        // Early release: producer 1 stops after 2 beats, producer 3 waiting.
        do_reset();
        en = 4'b1010;
        pcnt[1] = 2;
        pcnt[3] = 3;
        pdata[1][0] = 8'h40;
        pdata[1][1] = 8'h41;
        for (int b = 0; b < 3; b++) pdata[3][b] = 8'(8'h70 + b);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h41);
        for (int b = 0; b < 3; b++) exp_q.push_back(8'(8'h70 + b));
        apply();
        tick();
        expect_eq("early_grant1", 32'(grant), 32'h2);
        tick();
        tick();
        expect_eq("early_gap_wr", 32'(wr_en), 32'd0);
        expect_eq("early_gap_grant", 32'(grant), 32'h2);
        tick();
        expect_eq("early_grant3", 32'(grant), 32'h8);
        expect_eq("early_wr3", 32'(wr_en), 32'd1);
        expect_eq("early_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        drain("early_drained", 10);
        expect_eq("early_wr_count", 32'(wr_count), 32'd5);

        // Reset on beat 2 of producer 0; arbitration must restart at producer 0.
        do_reset();
        en = 4'b1001;
        pcnt[0] = 4;
        pcnt[3] = 1;
        for (int b = 0; b < 4; b++) pdata[0][b] = 8'(8'h50 + b);
        pdata[3][0] = 8'h60;
        exp_q.push_back(8'h50);
        apply();
        tick();
        expect_eq("mid_grant0", 32'(grant), 32'h1);
        expect_eq("mid_wr1", 32'(wr_en), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        expect_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
        expect_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        expect_eq("mid_wr_count", 32'(wr_count), 32'd0);
        expect_eq("mid_grant", 32'(grant), 32'd0);
        expect_eq("mid_busy", 32'(busy), 32'd0);
        for (int b = 1; b < 4; b++) exp_q.push_back(8'(8'h50 + b));
        exp_q.push_back(8'h60);
        rst = 1'b0;
        tick();
        expect_eq("mid_restart_grant", 32'(grant), 32'h1);
        drain("mid_drained", 20);
        expect_eq("mid_final_count", 32'(wr_count), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
